// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Holds the arbiter state encoding, port index constants and default widths.
package imem_arb_pkg;

    typedef enum logic [1:0] {
        OPEN  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } imem_arb_state_e;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_DATA  = 1'b1;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;
    localparam int MASK_W_DEF = DATA_W_DEF / 8;

    // The port that should win the next contested cycle after `port` was served.
    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/imem_arb_resp_router.sv
// Response router: remembers which port owns the access in flight and steers
// the memory's valid/data response back to that port only.
module imem_arb_resp_router
    import imem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              xfer,
    input  logic              xfer_port,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata
);

    logic tag_q,     tag_d;
    logic tag_vld_q, tag_vld_d;
    logic resp_vld;

    always_comb begin
        tag_d     = tag_q;
        tag_vld_d = xfer;
        if (xfer) begin
            tag_d = xfer_port;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_q     <= PORT_FETCH;
            tag_vld_q <= 1'b0;
        end else begin
            tag_q     <= tag_d;
            tag_vld_q <= tag_vld_d;
        end
    end

    // A memory valid with no tagged access in flight (e.g. one issued just before reset) is dropped.
    assign resp_vld  = mem_valid & tag_vld_q;
    assign p0_rvalid = resp_vld & (tag_q == PORT_FETCH);
    assign p1_rvalid = resp_vld & (tag_q == PORT_DATA);
    assign p0_rdata  = mem_data_out;
    assign p1_rdata  = mem_data_out;

endmodule

// File: rtl/imem_port_arbiter.sv
// Two-port arbiter for a single-port memory with exclusive lock bursts.
// IMEM_ARB_ROUND_ROBIN_EN selects an alternating pointer; otherwise port 1 wins contested cycles.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int MASK_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              p0_req,
    input  logic              p0_lock,
    input  logic              p0_we,
    input  logic [MASK_W-1:0] p0_mask,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,

    input  logic              p1_req,
    input  logic              p1_lock,
    input  logic              p1_we,
    input  logic [MASK_W-1:0] p1_mask,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,

    output logic              mem_request,
    output logic              mem_we_re,
    output logic [MASK_W-1:0] mem_mask,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data_out,

    output imem_arb_state_e   dbg_state
);

    // Handshake: a requester raises pN_req and holds lock/we/mask/addr/wdata
    // stable until pN_gnt; the access transfers at the posedge where both are
    // high. gnt is combinational, one-hot or zero, and is the memory request.
    // The response (rvalid, plus rdata for reads) arrives exactly one cycle later.

    imem_arb_state_e state_q, state_d;
    logic            gnt0_raw, gnt1_raw;
    logic            win_port;

    always_comb begin
        state_d  = state_q;
        gnt0_raw = 1'b0;
        gnt1_raw = 1'b0;
        unique case (state_q)
            OPEN: begin
                if (p0_req && p1_req) begin
                    if (win_port == PORT_DATA) begin
                        gnt1_raw = 1'b1;
                    end else begin
                        gnt0_raw = 1'b1;
                    end
                end else if (p0_req) begin
                    gnt0_raw = 1'b1;
                end else if (p1_req) begin
                    gnt1_raw = 1'b1;
                end
                if (gnt0_raw && p0_lock) begin
                    state_d = LOCK0;
                end else if (gnt1_raw && p1_lock) begin
                    state_d = LOCK1;
                end
            end
            // Owner keeps the memory through idle gaps; dropping lock (with or
            // without a final beat) hands it back.
            LOCK0: begin
                gnt0_raw = p0_req;
                if (!p0_lock) begin
                    state_d = OPEN;
                end
            end
            LOCK1: begin
                gnt1_raw = p1_req;
                if (!p1_lock) begin
                    state_d = OPEN;
                end
            end
            default: begin
                state_d = OPEN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= OPEN;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef IMEM_ARB_ROUND_ROBIN_EN
    logic ptr_q, ptr_d;

    // Any grant, locked or not, points at the other port for the next contest.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt0_raw) begin
            ptr_d = other_port(PORT_FETCH);
        end else if (gnt1_raw) begin
            ptr_d = other_port(PORT_DATA);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= PORT_FETCH;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign win_port = ptr_q;
`else
    assign win_port = PORT_DATA;
`endif

    // Grants are held off asynchronously while reset is low.
    assign p0_gnt      = gnt0_raw & rst;
    assign p1_gnt      = gnt1_raw & rst;
    assign mem_request = p0_gnt | p1_gnt;

    always_comb begin
        mem_we_re   = 1'b0;
        mem_mask    = '0;
        mem_address = '0;
        mem_data_in = '0;
        if (p0_gnt) begin
            mem_we_re   = p0_we;
            mem_mask    = p0_mask;
            mem_address = p0_addr;
            mem_data_in = p0_wdata;
        end else if (p1_gnt) begin
            mem_we_re   = p1_we;
            mem_mask    = p1_mask;
            mem_address = p1_addr;
            mem_data_in = p1_wdata;
        end
    end

    imem_arb_resp_router #(
        .DATA_W (DATA_W)
    ) u_resp_router (
        .clk          (clk),
        .rst          (rst),
        .xfer         (mem_request),
        .xfer_port    (p1_gnt),
        .mem_valid    (mem_valid),
        .mem_data_out (mem_data_out),
        .p0_rvalid    (p0_rvalid),
        .p1_rvalid    (p1_rvalid),
        .p0_rdata     (p0_rdata),
        .p1_rdata     (p1_rdata)
    );

    assign dbg_state = state_q;

endmodule
